// File: rtl/av_timing_pkg.sv
// ============================================================================
// av_timing_pkg : raster timing constant sets and total-length helper
// Rev 1.0
// ============================================================================
`default_nettype none

package av_timing_pkg;

    // 640x480 @ 60 Hz, active-low syncs
    localparam int c_VGA_H_ACTIVE  = 640;
    localparam int c_VGA_H_FP      = 16;
    localparam int c_VGA_H_SYNC    = 96;
    localparam int c_VGA_H_BP      = 48;
    localparam int c_VGA_V_ACTIVE  = 480;
    localparam int c_VGA_V_FP      = 10;
    localparam int c_VGA_V_SYNC    = 2;
    localparam int c_VGA_V_BP      = 33;
    localparam bit c_VGA_HSYNC_POL = 1'b0;
    localparam bit c_VGA_VSYNC_POL = 1'b0;

    // 1280x720 @ 60 Hz, active-high syncs
    localparam int c_HD_H_ACTIVE   = 1280;
    localparam int c_HD_H_FP       = 110;
    localparam int c_HD_H_SYNC     = 40;
    localparam int c_HD_H_BP       = 220;
    localparam int c_HD_V_ACTIVE   = 720;
    localparam int c_HD_V_FP       = 5;
    localparam int c_HD_V_SYNC     = 5;
    localparam int c_HD_V_BP       = 20;
    localparam bit c_HD_HSYNC_POL  = 1'b1;
    localparam bit c_HD_VSYNC_POL  = 1'b1;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timing_axis_counter.sv
// ============================================================================
// timing_axis_counter : one raster axis (active / front porch / sync / back porch)
// Rev 1.0
// ============================================================================
`default_nettype none

module timing_axis_counter
    import av_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int WIDTH  = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance_i,
    output logic [WIDTH-1:0] count_o,
    output logic             in_active_o,
    output logic             in_sync_o,
    output logic             wrap_o
);

    localparam int               c_TOTAL      = calc_total(ACTIVE, FP, SYNC, BP);
    localparam logic [WIDTH-1:0] c_LAST       = WIDTH'(c_TOTAL - 1);
    localparam logic [WIDTH-1:0] c_ACTIVE     = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] c_SYNC_START = WIDTH'(ACTIVE + FP);
    localparam logic [WIDTH-1:0] c_SYNC_END   = WIDTH'(ACTIVE + FP + SYNC);

    logic [WIDTH-1:0] count_q, count_d;
    logic             in_active_q, in_active_d;
    logic             in_sync_q, in_sync_d;
    logic             w_at_last;

    assign w_at_last = (count_q == c_LAST);

    // Region flags are derived from the next count so they always match count_o.
    always_comb begin
        count_d = count_q;
        if (advance_i) begin
            count_d = w_at_last ? '0 : count_q + 1'b1;
        end
        in_active_d = (count_d < c_ACTIVE);
        in_sync_d   = (count_d >= c_SYNC_START) && (count_d < c_SYNC_END);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= c_LAST;
            in_active_q <= 1'b0;
            in_sync_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            in_active_q <= in_active_d;
            in_sync_q   <= in_sync_d;
        end
    end

    assign count_o     = count_q;
    assign in_active_o = in_active_q;
    assign in_sync_o   = in_sync_q;
    assign wrap_o      = w_at_last;

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// video_timing_gen : pixel/line/frame raster timing with syncs and strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module video_timing_gen
    import av_timing_pkg::*;
#(
    parameter int H_ACTIVE    = c_VGA_H_ACTIVE,
    parameter int H_FP        = c_VGA_H_FP,
    parameter int H_SYNC      = c_VGA_H_SYNC,
    parameter int H_BP        = c_VGA_H_BP,
    parameter int V_ACTIVE    = c_VGA_V_ACTIVE,
    parameter int V_FP        = c_VGA_V_FP,
    parameter int V_SYNC      = c_VGA_V_SYNC,
    parameter int V_BP        = c_VGA_V_BP,
    parameter bit HSYNC_POL   = c_VGA_HSYNC_POL,
    parameter bit VSYNC_POL   = c_VGA_VSYNC_POL,
    parameter int COORD_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   active,
    output logic [COORD_WIDTH-1:0] pixel_x,
    output logic [COORD_WIDTH-1:0] pixel_y,
    output logic                   line_start,
    output logic                   frame_start
);

    localparam int c_H_TOTAL   = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL   = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_MAX_COORD = (c_H_TOTAL > c_V_TOTAL) ? c_H_TOTAL - 1 : c_V_TOTAL - 1;

    if ((H_ACTIVE <= 0) || (H_FP <= 0) || (H_SYNC <= 0) || (H_BP <= 0) ||
        (V_ACTIVE <= 0) || (V_FP <= 0) || (V_SYNC <= 0) || (V_BP <= 0) ||
        (COORD_WIDTH <= 0) ||
        (longint'(c_MAX_COORD) >= (longint'(1) << COORD_WIDTH))) begin : g_param_check
        $error("video_timing_gen: zero timing parameter or COORD_WIDTH too narrow");
    end

    logic w_h_active, w_h_sync, w_h_wrap;
    logic w_v_active, w_v_sync, w_v_wrap;
    logic w_v_advance;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // The vertical axis only moves on a line wrap, so vsync changes together with x=0.
    assign w_v_advance = enable && w_h_wrap;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .WIDTH  (COORD_WIDTH)
    ) u_h_axis (
        .clock       (clock),
        .reset       (reset),
        .advance_i   (enable),
        .count_o     (pixel_x),
        .in_active_o (w_h_active),
        .in_sync_o   (w_h_sync),
        .wrap_o      (w_h_wrap)
    );

    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .WIDTH  (COORD_WIDTH)
    ) u_v_axis (
        .clock       (clock),
        .reset       (reset),
        .advance_i   (w_v_advance),
        .count_o     (pixel_y),
        .in_active_o (w_v_active),
        .in_sync_o   (w_v_sync),
        .wrap_o      (w_v_wrap)
    );

    always_comb begin
        line_start_d  = enable && w_h_wrap;
        frame_start_d = enable && w_h_wrap && w_v_wrap;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Flags are flop outputs; polarity is a constant so sync stays glitch-free.
    assign active      = w_h_active && w_v_active;
    assign hsync       = w_h_sync ? HSYNC_POL : !HSYNC_POL;
    assign vsync       = w_v_sync ? VSYNC_POL : !VSYNC_POL;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire
